// File: rtl/param_counter.sv
// Parametrised up/down counter with a runtime inclusive bound, parallel load, wrap or saturate
// at the bounds, a registered terminal-count pulse and sticky overflow/underflow flags.
module param_counter #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned SATURATE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic [WIDTH-1:0] max_value,
    input  logic             clear_flags,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             overflow,
    output logic             underflow
);

    localparam bit Sat = (SATURATE != 0);

    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             ovf_event, unf_event;

    always_comb begin
        count_d   = count_q;
        tc_d      = 1'b0;
        ovf_event = 1'b0;
        unf_event = 1'b0;

        if (load) begin
            count_d = (load_value > max_value) ? max_value : load_value;
        end else if (enable) begin
            if (up_down) begin
                if (count_q >= max_value) begin
                    count_d   = Sat ? max_value : '0;
                    tc_d      = 1'b1;
                    ovf_event = 1'b1;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end else begin
                if (count_q == '0) begin
                    count_d   = Sat ? '0 : max_value;
                    tc_d      = 1'b1;
                    unf_event = 1'b1;
                end else if (count_q > max_value) begin
                    // Bound was lowered under the count: pull back into range quietly.
                    count_d = max_value;
                end else begin
                    count_d = count_q - 1'b1;
                end
            end
        end

        // A new event in the same cycle as clear_flags keeps the flag set.
        overflow_d  = ovf_event | (overflow_q & ~clear_flags);
        underflow_d = unf_event | (underflow_q & ~clear_flags);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q     <= '0;
            tc_q        <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            tc_q        <= tc_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign count     = count_q;
    assign tc        = tc_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_param_counter.sv
// Directed bench for param_counter: a wrapping instance and a saturating instance share
// the same stimulus; each check names which instance it looks at.
module tb_param_counter;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         reset, enable, up_down, load, clear_flags;
    logic [W-1:0] load_value, max_value;

    logic [W-1:0] w_count, s_count;
    logic         w_tc, w_ovf, w_unf;
    logic         s_tc, s_ovf, s_unf;

    int unsigned tests_run = 0;
    int unsigned tests_failed = 0;

    param_counter #(.WIDTH(W), .SATURATE(0)) u_wrap (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .up_down    (up_down),
        .load       (load),
        .load_value (load_value),
        .max_value  (max_value),
        .clear_flags(clear_flags),
        .count      (w_count),
        .tc         (w_tc),
        .overflow   (w_ovf),
        .underflow  (w_unf)
    );

    param_counter #(.WIDTH(W), .SATURATE(1)) u_sat (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .up_down    (up_down),
        .load       (load),
        .load_value (load_value),
        .max_value  (max_value),
        .clear_flags(clear_flags),
        .count      (s_count),
        .tc         (s_tc),
        .overflow   (s_ovf),
        .underflow  (s_unf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset = 1'b0; enable = 1'b0; load = 1'b0; clear_flags = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        idle();
        up_down    = 1'b1;
        load_value = '0;
        max_value  = 8'd255;

        // Reset state
        do_reset();
        check("rst count", w_count, 0);
        check("rst tc", w_tc, 0);
        check("rst ovf", w_ovf, 0);
        check("rst unf", w_unf, 0);

        // Free-running rollover with M=255 over 257 steps
        enable = 1'b1; up_down = 1'b1;
        for (int i = 1; i <= 257; i++) begin
            tick();
            check($sformatf("roll count %0d", i), w_count, i % 256);
            check($sformatf("roll tc %0d", i), w_tc, (i == 256) ? 1 : 0);
        end
        check("roll ovf", w_ovf, 1);
        check("roll unf", w_unf, 0);

        // Down from 0 with M=9 wraps to 9
        do_reset();
        max_value = 8'd9; enable = 1'b1; up_down = 1'b0;
        tick();
        check("dn wrap count", w_count, 9);
        check("dn wrap tc", w_tc, 1);
        check("dn wrap unf", w_unf, 1);
        check("dn sat count", s_count, 0);
        tick();
        check("dn count 8", w_count, 8);
        check("dn tc low", w_tc, 0);
        tick();
        check("dn count 7", w_count, 7);
        check("dn ovf", w_ovf, 0);

        // Saturating instance: M=5, load 4, three up steps
        do_reset();
        max_value = 8'd5; load = 1'b1; load_value = 8'd4;
        tick();
        check("sat load", s_count, 4);
        load = 1'b0; enable = 1'b1; up_down = 1'b1;
        tick();
        check("sat s1 count", s_count, 5);
        check("sat s1 tc", s_tc, 0);
        tick();
        check("sat s2 count", s_count, 5);
        check("sat s2 tc", s_tc, 1);
        check("sat s2 ovf", s_ovf, 1);
        check("wrap s2 count", w_count, 0);
        tick();
        check("sat s3 count", s_count, 5);
        check("sat s3 tc", s_tc, 1);
        enable = 1'b0; clear_flags = 1'b1;
        tick();
        check("sat clr ovf", s_ovf, 0);
        check("sat clr count", s_count, 5);
        check("sat clr tc", s_tc, 0);
        clear_flags = 1'b0;

        // Load clamping, load-over-enable, lowered bound
        do_reset();
        max_value = 8'd100; load = 1'b1; load_value = 8'd200;
        tick();
        check("load clamp", w_count, 100);
        load_value = 8'd30; enable = 1'b1; up_down = 1'b1;
        tick();
        check("load wins", w_count, 30);
        check("load wins tc", w_tc, 0);
        enable = 1'b0; load_value = 8'd80;
        tick();
        check("load 80", w_count, 80);
        load = 1'b0; max_value = 8'd50; enable = 1'b1; up_down = 1'b0;
        tick();
        check("lowered count", w_count, 50);
        check("lowered tc", w_tc, 0);
        check("lowered unf", w_unf, 0);
        check("lowered ovf", w_ovf, 0);

        // Reset beats load and enable mid-count
        do_reset();
        max_value = 8'd0; enable = 1'b1; up_down = 1'b1;
        tick();
        enable = 1'b0; max_value = 8'd255; load = 1'b1; load_value = 8'd37;
        tick();
        check("pre-rst count", w_count, 37);
        check("pre-rst ovf", w_ovf, 1);
        reset = 1'b1; enable = 1'b1;
        tick();
        check("mid rst count", w_count, 0);
        check("mid rst tc", w_tc, 0);
        check("mid rst ovf", w_ovf, 0);
        check("mid rst unf", w_unf, 0);

        // clear_flags coinciding with a wrap: set wins
        do_reset();
        max_value = 8'd3; load = 1'b1; load_value = 8'd3;
        tick();
        load = 1'b0; enable = 1'b1; up_down = 1'b1; clear_flags = 1'b1;
        tick();
        check("clr+wrap ovf", w_ovf, 1);
        check("clr+wrap count", w_count, 0);
        check("clr+wrap tc", w_tc, 1);
        clear_flags = 1'b0;

        // M=0: every step is a boundary event
        max_value = 8'd0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("m0 count %0d", i), w_count, 0);
            check($sformatf("m0 tc %0d", i), w_tc, 1);
            check($sformatf("m0 sat tc %0d", i), s_tc, 1);
        end
        up_down = 1'b0;
        tick();
        check("m0 dn unf", w_unf, 1);
        check("m0 dn count", w_count, 0);
        enable = 1'b0;
        tick();
        check("m0 idle tc", w_tc, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/param_counter.md
Name: param_counter

Overview:
Parametrised up/down counter, the next generation of the fixed 8-bit up counter. Adds programmable width and runtime upper bound (modulo), direction control, parallel load, wrap-or-saturate mode, a terminal-count pulse and sticky overflow/underflow flags. Used as a general event, timeout and index counter inside datapath and control blocks.

Parameters:
WIDTH, 8, counter width in bits (≥2).
SATURATE, 0, 0 = wrap at bounds, 1 = hold (saturate) at bounds.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  synchronous, active-high reset.
enable  input  1  count step request, one step per cycle while high.
up_down  input  1  1 = count up, 0 = count down; sampled only when a step occurs.
load  input  1  parallel load strobe.
load_value  input  WIDTH  value loaded when load=1.
max_value  input  WIDTH  inclusive upper bound; legal count range 0..max_value.
clear_flags  input  1  clears overflow/underflow.
count  output  WIDTH  current count, registered.
tc  output  1  terminal-count pulse, registered, one cycle wide.
overflow  output  1  sticky: an up step occurred at/above max_value.
underflow  output  1  sticky: a down step occurred at 0.

Behaviour:
- All state updates on posedge clk; all outputs registered, no combinational paths from inputs to outputs.
- Reset (synchronous): count=0, tc=0, overflow=0, underflow=0. Overrides every other input in the same cycle.
- Priority per cycle: reset > load > enable.
- Load: count <= load_value if load_value ≤ max_value, else count <= max_value. Load never sets tc or flags. Load with enable=1 in the same cycle: load wins, no step.
- Step (enable=1, load=0), count C, bound M:
  - Up, C < M: count <= C+1.
  - Up, C ≥ M (boundary event): count <= 0 if SATURATE=0, count <= M if SATURATE=1; tc pulses next cycle; overflow set.
  - Down, C = 0 (boundary event): count <= M if SATURATE=0, count <= 0 if SATURATE=1; tc pulses next cycle; underflow set.
  - Down, C > M (bound lowered at runtime): count <= M, no tc, no flag.
  - Down, 0 < C ≤ M: count <= C-1.
- enable=0 and load=0: count holds; tc=0.
- tc: high for exactly the one cycle after each boundary event. Consecutive boundary events (e.g. saturated with enable held) give tc high every cycle.
- Flags: set on their boundary event, held until clear_flags or reset. clear_flags and a new event in the same cycle: the flag stays set (set wins). clear_flags does not affect count or tc.
- M = 0: count stays 0; every enabled step is a boundary event (up → overflow, down → underflow).
- M = 2^WIDTH−1 with SATURATE=0 reproduces the free-running rollover counter behaviour.
- Arithmetic is WIDTH bits, unsigned; no intermediate value may exceed WIDTH+1 bits.
- max_value may change at any cycle; it takes effect on the next step or load decision.

Test Plan:
- WIDTH=8, SATURATE=0, M=255, up, enable held 257 cycles from reset → count 0,1,…,255,0,1; tc high exactly once (the cycle count shows 0 after 255); overflow=1.
- WIDTH=8, M=9, SATURATE=0, down from 0 → count 9,8,…; tc pulse after wrap to 9; underflow=1, overflow=0.
- SATURATE=1, M=5, load 4, up 3 steps → count 5,5,5; tc high for 2 cycles; overflow=1. Then clear_flags → overflow=0, count holds 5.
- Load 200 with M=100 → count=100. Load and enable asserted together → load value taken, no step. Lower M to 50 then step down → count=50, no flags.
- Reset asserted mid-count (count=37, overflow=1, load=1 in the same cycle) → next cycle count=0, tc=0, both flags 0.
- clear_flags in the same cycle as an up wrap → overflow remains 1. M=0 with enable up → count stays 0, tc high every cycle.
